jh_dac_burst_seq: RTL
=====================

Name: jh_dac_burst_seq

Overview:
- Sequencer for the ADDA sine-generator datapath; drives its DAC_rst and 6-bit gain inputs.
- Produces repeated tone bursts: soft gain ramp-up, hold, ramp-down, gap, repeated burst_count times.
- Measures ADC peak-to-peak during each hold window for loopback/level monitoring.
- Sits between the control logic (start/abort/config) and the ADDA block, in the CLOCK_50 domain.

Parameters:
- GAIN_W, 6, gain width; matches the ADDA gain input.
- STEP_DIV, 50, CLOCK_50 cycles per ±1 gain step; 50 gives 1 us per step. Legal range ≥1.
- CNT_W, 24, width of the hold and gap counters.
- ADC_W, 14, ADC sample width.

Ports:
- CLOCK_50 in 1: system clock; all logic on the rising edge.
- RESET_N in 1: asynchronous, active-low reset.
- start in 1: pulse; begins a sequence if idle.
- abort in 1: pulse; forces an orderly ramp-down, then idle.
- target_gain in GAIN_W: hold-level gain; latched at start.
- hold_cycles in CNT_W: cycles at target gain per burst; latched at start. 0 is treated as 1.
- gap_cycles in CNT_W: cycles at gain 0 between bursts; latched at start.
- burst_count in 8: number of bursts; latched at start. 0 means continuous until abort.
- ADC_in in ADC_W: registered ADC sample, offset binary.
- DAC_rst out 1: to the ADDA DAC_rst input.
- gain out GAIN_W: to the ADDA gain input.
- busy out 1: high whenever state != IDLE.
- done out 1: one-cycle pulse on return to IDLE.
- bursts_done out 8: completed bursts in the current or last sequence; saturates at 255.
- adc_p2p out ADC_W: max−min of ADC_in over the last completed hold window.
- adc_p2p_valid out 1: one-cycle pulse when adc_p2p updates.

Behaviour:
- Reset values:
  - DAC_rst=1, gain=0, busy=0, done=0, bursts_done=0, adc_p2p=0, adc_p2p_valid=0.
  - state=IDLE; prescaler and counters 0.
- States: IDLE, RAMP_UP, HOLD, RAMP_DOWN, GAP.
- IDLE:
  - DAC_rst=1, gain=0.
  - On start: latch the config, clear bursts_done, go to RAMP_UP, DAC_rst=0 from the next cycle.
  - If target_gain==0 at start: no burst; done pulses the next cycle; stay IDLE.
- RAMP_UP:
  - The prescaler counts STEP_DIV cycles, then gain increments by 1.
  - When the gain reaches target, go to HOLD.
  - Latency from start to gain==target is 1 + target*STEP_DIV cycles.
- HOLD:
  - gain=target for hold_cycles cycles.
  - Track min/max of ADC_in every cycle; min/max are initialised from the first HOLD sample.
  - On exit: adc_p2p=max−min (unsigned, never negative) and adc_p2p_valid pulses. Then go to RAMP_DOWN.
- RAMP_DOWN:
  - Gain decrements by 1 every STEP_DIV cycles.
  - At gain==0: increment bursts_done.
  - If the burst is the last (bursts_done+1==burst_count, burst_count≠0) or abort is pending: go to IDLE and pulse done.
  - Otherwise go to GAP.
- GAP:
  - gain=0, DAC_rst stays 0 (tone stays phase-continuous), for gap_cycles cycles.
  - gap_cycles==0 means go straight to RAMP_UP.
- Abort:
  - Set a sticky abort_pend flag.
  - From RAMP_UP or HOLD: go to RAMP_DOWN next cycle, from the current gain. No adc_p2p update if HOLD is cut short.
  - From GAP: go to IDLE with a done pulse.
  - From RAMP_DOWN: continue the ramp-down.
  - In IDLE: ignored.
- Start while busy: ignored. Config input changes while busy: ignored (latched values are used).
- Start and abort in the same IDLE cycle: abort wins; stay IDLE, no done pulse.
- The prescaler restarts at 0 on every state entry. Gain never exceeds target and never underflows below 0.
- RESET_N asserted mid-operation: all outputs return to reset values immediately (asynchronously), including DAC_rst=1.

Optional Feature:
- JH_SEQ_SOFT_RAMP_EN
  - Defined: stepped ramps as described above.
  - Undefined: RAMP_UP and RAMP_DOWN each last exactly 1 cycle, and gain jumps to target or 0 directly. STEP_DIV is unused.
  - All other behaviour is identical in both builds.

Decomposition:
- Package jh_adda_pkg:
  - State enum.
  - GAIN_MAX=63, ADC_MID=8192.
  - Default widths GAIN_W, ADC_W, CNT_W.
- Sub-module jh_adc_p2p: min/max tracker with clear, enable and a latch strobe. Outputs p2p and valid.
- Prescaler and FSM stay in the top module.

Test Plan:
- Basic burst: STEP_DIV=2, target=4, hold=10, gap=5, burst_count=1, start.
  - gain steps 0→4 every 2 cycles, then holds 10 cycles, then 4→0.
  - done pulses once; bursts_done=1; DAC_rst returns to 1.
- Peak measurement: ADC_in toggles 8000/8400 during HOLD.
  - adc_p2p=400 with a single adc_p2p_valid pulse at the end of HOLD.
- Abort: abort mid-HOLD with gain=4.
  - Ramp-down starts next cycle; no adc_p2p_valid pulse.
  - done pulses; bursts_done=1; no GAP entered.
- Continuous mode: burst_count=0, run 3 bursts, then abort during GAP.
  - bursts_done=3; IDLE the next cycle; done pulses.
- Edge cases:
  - target=0 at start: done pulses the next cycle, busy stays 0.
  - start while busy: no effect.
  - hold=0: HOLD lasts 1 cycle.
  - start+abort in the same cycle: stay IDLE.
- Reset and build variants:
  - RESET_N low mid-RAMP_UP: gain=0 and DAC_rst=1 immediately.
  - Without JH_SEQ_SOFT_RAMP_EN: gain goes 0→4 in one cycle.

Source files
------------

// File: rtl/jh_adda_pkg.sv
// Shared types and default widths for the ADDA burst sequencer and its helpers.
// Widths match the ADDA gain input and the registered ADC sample bus.
package jh_adda_pkg;

   localparam int GAIN_W   = 6;
   localparam int ADC_W    = 14;
   localparam int CNT_W    = 24;
   localparam int GAIN_MAX = 63;
   localparam int ADC_MID  = 8192;

   typedef enum logic [2:0] {
      IDLE,
      RAMP_UP,
      HOLD,
      RAMP_DOWN,
      GAP
   } seq_state_t;

endpackage

// File: rtl/jh_dac_burst_seq_if.sv
// Control/config/ADDA bundle between the controller and the burst sequencer.
// master = controller side (drives start/abort/config/ADC sample), slave = sequencer.
interface jh_dac_burst_seq_if #(
   parameter int GAIN_W = jh_adda_pkg::GAIN_W,
   parameter int CNT_W  = jh_adda_pkg::CNT_W,
   parameter int ADC_W  = jh_adda_pkg::ADC_W
);
   logic              start;
   logic              abort;
   logic [GAIN_W-1:0] target_gain;
   logic [CNT_W-1:0]  hold_cycles;
   logic [CNT_W-1:0]  gap_cycles;
   logic [7:0]        burst_count;
   logic [ADC_W-1:0]  ADC_in;
   logic              DAC_rst;
   logic [GAIN_W-1:0] gain;
   logic              busy;
   logic              done;
   logic [7:0]        bursts_done;
   logic [ADC_W-1:0]  adc_p2p;
   logic              adc_p2p_valid;

   modport master (
      output start, abort, target_gain, hold_cycles, gap_cycles, burst_count, ADC_in,
      input  DAC_rst, gain, busy, done, bursts_done, adc_p2p, adc_p2p_valid
   );

   modport slave (
      input  start, abort, target_gain, hold_cycles, gap_cycles, burst_count, ADC_in,
      output DAC_rst, gain, busy, done, bursts_done, adc_p2p, adc_p2p_valid
   );
endinterface

// File: rtl/jh_adc_p2p.sv
// Min/max tracker over a sample window; clr restarts the window from the current sample.
// lat publishes max-min (including the current sample) and pulses p2p_valid one cycle later.
module jh_adc_p2p #(
   parameter int ADC_W = jh_adda_pkg::ADC_W
)(
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic             clr,
   input  logic             en,
   input  logic             lat,
   input  logic [ADC_W-1:0] sample,
   output logic [ADC_W-1:0] p2p,
   output logic             p2p_valid
);
   logic [ADC_W-1:0] min_q, max_q, cur_min, cur_max;

   assign cur_min = (clr || (sample < min_q)) ? sample : min_q;
   assign cur_max = (clr || (sample > max_q)) ? sample : max_q;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         min_q     <= '0;
         max_q     <= '0;
         p2p       <= '0;
         p2p_valid <= 1'b0;
      end else begin
         if (en) begin
            min_q <= cur_min;
            max_q <= cur_max;
         end
         p2p_valid <= lat;
         if (lat) p2p <= cur_max - cur_min;
      end
   end
endmodule

// File: rtl/jh_dac_burst_seq.sv
// Tone-burst sequencer for the ADDA sine datapath: gain ramp-up, hold, ramp-down, gap, repeated.
// Define JH_SEQ_SOFT_RAMP_EN for stepped ramps (one gain step every STEP_DIV cycles); otherwise ramps take one cycle.
module jh_dac_burst_seq
   import jh_adda_pkg::*;
#(
   parameter int GAIN_W   = jh_adda_pkg::GAIN_W,
   parameter int STEP_DIV = 50,
   parameter int CNT_W    = jh_adda_pkg::CNT_W,
   parameter int ADC_W    = jh_adda_pkg::ADC_W
)(
   input logic               CLOCK_50,
   input logic               RESET_N,
   jh_dac_burst_seq_if.slave bus
);
   localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   seq_state_t        state, state_nxt;
   logic [GAIN_W-1:0] gain_q, gain_nxt, tgt_q, gain_up, gain_dn;
   logic [CNT_W-1:0]  hold_q, gap_q, cnt_q, cnt_nxt;
   logic [7:0]        nb_q, bd_q, bd_nxt, bd_inc;
   logic [PW-1:0]     presc_q, presc_nxt;
   logic              abort_pend_q, abort_pend_nxt, done_q, done_nxt, cfg_ld;
   logic              step_tick, hold_end, last_burst, ramp_fin;
   logic              trk_clr, trk_en, trk_lat;

`ifdef JH_SEQ_SOFT_RAMP_EN
   assign step_tick = (presc_q == PW'(STEP_DIV - 1));
   assign gain_up   = gain_q + GAIN_W'(1);
   assign gain_dn   = gain_q - GAIN_W'(1);
`else
   assign step_tick = 1'b1;
   assign gain_up   = tgt_q;
   assign gain_dn   = '0;
`endif

   // hold_cycles==0 behaves as a one-cycle hold
   assign hold_end   = (hold_q == '0) || (cnt_q == hold_q - CNT_W'(1));
   assign bd_inc     = (bd_q == 8'hFF) ? bd_q : bd_q + 8'd1;
   assign last_burst = (nb_q != 8'd0) && (({1'b0, bd_q} + 9'd1) == {1'b0, nb_q});
   assign ramp_fin   = (gain_q == '0) || (step_tick && (gain_dn == '0));

   always_comb begin
      state_nxt      = state;
      gain_nxt       = gain_q;
      cnt_nxt        = '0;
      presc_nxt      = '0;
      bd_nxt         = bd_q;
      abort_pend_nxt = abort_pend_q;
      done_nxt       = 1'b0;
      cfg_ld         = 1'b0;
      trk_clr        = 1'b0;
      trk_en         = 1'b0;
      trk_lat        = 1'b0;
      case (state)
         IDLE: begin
            gain_nxt       = '0;
            abort_pend_nxt = 1'b0;
            if (bus.start && !bus.abort) begin
               cfg_ld = 1'b1;
               bd_nxt = 8'd0;
               if (bus.target_gain == '0) done_nxt  = 1'b1;
               else                       state_nxt = RAMP_UP;
            end
         end
         RAMP_UP: begin
            if (bus.abort) begin
               abort_pend_nxt = 1'b1;
               state_nxt      = RAMP_DOWN;
            end else if (step_tick) begin
               gain_nxt = gain_up;
               if (gain_up == tgt_q) state_nxt = HOLD;
            end else begin
               presc_nxt = presc_q + PW'(1);
            end
         end
         HOLD: begin
            trk_en  = 1'b1;
            trk_clr = (cnt_q == '0);
            if (bus.abort) begin
               abort_pend_nxt = 1'b1;
               state_nxt      = RAMP_DOWN;
            end else if (hold_end) begin
               trk_lat   = 1'b1;
               state_nxt = RAMP_DOWN;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         RAMP_DOWN: begin
            if (bus.abort) abort_pend_nxt = 1'b1;
            if (ramp_fin) begin
               gain_nxt = '0;
               bd_nxt   = bd_inc;
               if (last_burst || bus.abort || abort_pend_q) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else if (gap_q == '0) begin
                  state_nxt = RAMP_UP;
               end else begin
                  state_nxt = GAP;
               end
            end else if (step_tick) begin
               gain_nxt = gain_dn;
            end else begin
               presc_nxt = presc_q + PW'(1);
            end
         end
         GAP: begin
            if (bus.abort) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else if (cnt_q == gap_q - CNT_W'(1)) begin
               state_nxt = RAMP_UP;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state        <= IDLE;
         gain_q       <= '0;
         cnt_q        <= '0;
         presc_q      <= '0;
         bd_q         <= 8'd0;
         abort_pend_q <= 1'b0;
         done_q       <= 1'b0;
         tgt_q        <= '0;
         hold_q       <= '0;
         gap_q        <= '0;
         nb_q         <= 8'd0;
      end else begin
         state        <= state_nxt;
         gain_q       <= gain_nxt;
         cnt_q        <= cnt_nxt;
         presc_q      <= presc_nxt;
         bd_q         <= bd_nxt;
         abort_pend_q <= abort_pend_nxt;
         done_q       <= done_nxt;
         if (cfg_ld) begin
            tgt_q  <= bus.target_gain;
            hold_q <= bus.hold_cycles;
            gap_q  <= bus.gap_cycles;
            nb_q   <= bus.burst_count;
         end
      end
   end

   jh_adc_p2p #(.ADC_W(ADC_W)) u_p2p (
      .CLOCK_50  (CLOCK_50),
      .RESET_N   (RESET_N),
      .clr       (trk_clr),
      .en        (trk_en),
      .lat       (trk_lat),
      .sample    (bus.ADC_in),
      .p2p       (bus.adc_p2p),
      .p2p_valid (bus.adc_p2p_valid)
   );

   // DAC_rst follows the state register so an async reset reasserts it at once
   assign bus.DAC_rst     = (state == IDLE);
   assign bus.busy        = (state != IDLE);
   assign bus.gain        = gain_q;
   assign bus.done        = done_q;
   assign bus.bursts_done = bd_q;
endmodule
